bcd_display_ctrl: RTL and testbench

Sequential front end for the calculator's 4-digit 7-segment display.
- Accepts a W-bit signed value on a Start strobe and converts its magnitude to BCD with an iterative shift-add-3 (double-dabble) sequencer.
- Replaces the combinational divide/modulo path.
- Latches the Sign/D2/D1/D0 segment codes and holds them until the next conversion completes.
- Sits between the ALU result register and the HEX display pins.

---
 rtl/display_pkg.sv | 40 ++++
 rtl/bcd_display_ctrl_if.sv | 28 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_display_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_display_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the calculator display front end: active-low
// segment codes (gfedcba order), sequencer state encoding and the
// shift-add-3 nibble correction used by the BCD converter.
package display_pkg;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_BITS   = 4 * BCD_DIGITS;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] ZERO  = 7'b1000000;
   localparam logic [6:0] ONE   = 7'b1111001;
   localparam logic [6:0] TWO   = 7'b0100100;
   localparam logic [6:0] THREE = 7'b0110000;
   localparam logic [6:0] FOUR  = 7'b0011001;
   localparam logic [6:0] FIVE  = 7'b0010010;
   localparam logic [6:0] SIX   = 7'b0000010;
   localparam logic [6:0] SEVEN = 7'b1111000;
   localparam logic [6:0] EIGHT = 7'b0000000;
   localparam logic [6:0] NINE  = 7'b0010000;
   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] OFF   = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Double-dabble correction: every nibble that is 5 or more gets +3 so
   // that the following left shift carries correctly into the next digit.
   function automatic logic [BCD_BITS-1:0] add3(input logic [BCD_BITS-1:0] bcd);
      logic [BCD_BITS-1:0] r;
      r = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Request/result bundle between the ALU result register (master) and the
// display controller (slave). Clock and reset are kept as plain ports.
interface bcd_display_ctrl_if #(
   parameter int W = 11
);

   logic         Start;
   logic [W-1:0] N;
   logic         Encoding;
   logic         Busy;
   logic         Done;
   logic [6:0]   Sign;
   logic [6:0]   D2;
   logic [6:0]   D1;
   logic [6:0]   D0;
   logic         TooLarge;

   modport master (
      output Start, N, Encoding,
      input  Busy, Done, Sign, D2, D1, D0, TooLarge
   );

   modport slave (
      input  Start, N, Encoding,
      output Busy, Done, Sign, D2, D1, D0, TooLarge
   );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code. Non-decimal codes blank the digit.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup from digit value to segment pattern.
   always_comb begin
      // NOTE: default assignment first so every path drives seg and no latch is inferred.
      seg = OFF;
      case (bcd)
         4'd0:    seg = ZERO;
         4'd1:    seg = ONE;
         4'd2:    seg = TWO;
         4'd3:    seg = THREE;
         4'd4:    seg = FOUR;
         4'd5:    seg = FIVE;
         4'd6:    seg = SIX;
         4'd7:    seg = SEVEN;
         4'd8:    seg = EIGHT;
         4'd9:    seg = NINE;
         default: seg = OFF;
      endcase
   end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential 4-digit display front end. Captures a signed value on Start,
// converts its magnitude to BCD one bit per cycle (shift-add-3), then
// latches sign/hundreds/tens/ones segment codes until the next conversion.
module bcd_display_ctrl
   import display_pkg::*;
#(
   parameter int W = 11
) (
   input  logic               Clock,
   input  logic               Reset,
   bcd_display_ctrl_if.slave  bus
);

   localparam int CW = $clog2(W + 1);

   state_t                state;
   logic [W-1:0]          mag_q;
   logic [BCD_BITS-1:0]   bcd_q;
   logic [BCD_BITS-1:0]   bcd_adj;
   logic [CW-1:0]         cnt;
   logic                  neg_q;
   logic                  done_q;
   logic                  too_q;
   logic [6:0]            sign_q;
   logic [6:0]            d2_q;
   logic [6:0]            d1_q;
   logic [6:0]            d0_q;

   logic [W:0]            n_ext;
   logic [W:0]            load_mag;
   logic [3:0]            thousands;
   logic [3:0]            hundreds;
   logic [3:0]            tens;
   logic [6:0]            seg_hund;
   logic [6:0]            seg_tens;
   logic [6:0]            seg_ones;
   logic                  too_large;

   // The negation is done one bit wider so the most negative two's
   // complement input becomes +2^(W-1) instead of wrapping back to itself.
   assign n_ext = {bus.N[W-1], bus.N};

   // Magnitude of the incoming value under the selected number encoding.
   always_comb begin
      load_mag = '0;
      if (bus.Encoding) begin
         load_mag = bus.N[W-1] ? -n_ext : n_ext;
      end else begin
         load_mag = {2'b00, bus.N[W-2:0]};
      end
   end

   assign bcd_adj   = add3(bcd_q);
   assign thousands = bcd_q[15:12];
   assign hundreds  = bcd_q[11:8];
   assign tens      = bcd_q[7:4];
   assign too_large = (thousands != 4'd0);

   seg7_decode u_hund (.bcd(hundreds),    .seg(seg_hund));
   seg7_decode u_tens (.bcd(tens),        .seg(seg_tens));
   seg7_decode u_ones (.bcd(bcd_q[3:0]),  .seg(seg_ones));

   // Conversion sequencer: load on Start, W shift steps, one hand-over
   // cycle when the step counter is exhausted, then latch the display.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state  <= IDLE;
         mag_q  <= '0;
         bcd_q  <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         done_q <= 1'b0;
         too_q  <= 1'b0;
         sign_q <= OFF;
         d2_q   <= OFF;
         d1_q   <= OFF;
         d0_q   <= OFF;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Start) begin
                  mag_q <= load_mag[W-1:0];
                  // Sign-magnitude "-0" has a zero magnitude and shows no minus.
                  neg_q <= bus.N[W-1] && (load_mag != '0);
                  bcd_q <= '0;
                  cnt   <= CW'(W);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // cnt counts shift steps still owed; finding it at zero ends SHIFT.
               if (cnt == '0) begin
                  state <= UPDATE;
               end else begin
                  {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                  cnt            <= cnt - 1'b1;
               end
            end
            UPDATE: begin
               too_q <= too_large;
               if (too_large) begin
                  sign_q <= MINUS;
                  d2_q   <= MINUS;
                  d1_q   <= MINUS;
                  d0_q   <= MINUS;
               end else begin
                  sign_q <= neg_q ? MINUS : OFF;
                  // Leading-zero blanking: hundreds, then tens if hundreds also blank.
                  d2_q   <= (hundreds == 4'd0) ? OFF : seg_hund;
                  d1_q   <= (hundreds == 4'd0 && tens == 4'd0) ? OFF : seg_tens;
                  d0_q   <= seg_ones;
               end
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Busy     = (state != IDLE);
   assign bus.Done     = done_q;
   assign bus.TooLarge = too_q;
   assign bus.Sign     = sign_q;
   assign bus.D2       = d2_q;
   assign bus.D1       = d1_q;
   assign bus.D0       = d0_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: a decimal-arithmetic model of
// the display checked every cycle, plus literal expectations per scenario.
module tb_bcd_display_ctrl;

   localparam int W = 11;

   localparam logic [6:0] S_MINUS = 7'b0111111;
   localparam logic [6:0] S_OFF   = 7'b1111111;

   typedef struct packed {
      logic [6:0] sign;
      logic [6:0] d2;
      logic [6:0] d1;
      logic [6:0] d0;
      logic       too;
   } disp_t;

   localparam disp_t BLANK = {S_OFF, S_OFF, S_OFF, S_OFF, 1'b0};

   logic Clock = 1'b0;
   logic Reset;

   bcd_display_ctrl_if #(.W(W)) bus ();

   bcd_display_ctrl #(.W(W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_pass   = 0;
   logic cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
   endtask

   // Reference digit shapes written out from the display datasheet.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return S_OFF;
      endcase
   endfunction

   // What the display must show for a given input, via plain decimal arithmetic.
   function automatic disp_t expect_disp(input logic [W-1:0] n, input logic enc);
      int    mag;
      bit    neg;
      disp_t r;
      if (enc) mag = n[W-1] ? (1 << W) - int'(n) : int'(n);
      else     mag = int'(n[W-2:0]);
      neg = n[W-1] && (mag != 0);
      if (mag > 999) begin
         r = {S_MINUS, S_MINUS, S_MINUS, S_MINUS, 1'b1};
      end else begin
         r.sign = neg ? S_MINUS : S_OFF;
         r.d2   = (mag < 100) ? S_OFF : seg_of(mag / 100);
         r.d1   = (mag < 10)  ? S_OFF : seg_of((mag / 10) % 10);
         r.d0   = seg_of(mag % 10);
         r.too  = 1'b0;
      end
      return r;
   endfunction

   // Model: a conversion occupies W+2 cycles from its accepting edge; the
   // result appears with a one-cycle Done at the last of them.
   int    m_left;
   logic  m_done;
   disp_t m_disp;
   disp_t m_pend;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_disp <= BLANK;
         m_pend <= BLANK;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_disp <= m_pend;
               m_done <= 1'b1;
            end
         end else if (bus.Start) begin
            m_pend <= expect_disp(bus.N, bus.Encoding);
            m_left <= W + 2;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clock) begin
      if (cmp_en) begin
         check("busy",     bus.Busy,     m_left != 0);
         check("done",     bus.Done,     m_done);
         check("sign",     bus.Sign,     m_disp.sign);
         check("d2",       bus.D2,       m_disp.d2);
         check("d1",       bus.D1,       m_disp.d1);
         check("d0",       bus.D0,       m_disp.d0);
         check("toolarge", bus.TooLarge, m_disp.too);
      end
   end

   task automatic chk_disp(input string tag, input logic [6:0] s, input logic [6:0] h,
                           input logic [6:0] t, input logic [6:0] o, input logic too);
      check({tag, ".sign"}, bus.Sign,     s);
      check({tag, ".d2"},   bus.D2,       h);
      check({tag, ".d1"},   bus.D1,       t);
      check({tag, ".d0"},   bus.D0,       o);
      check({tag, ".too"},  bus.TooLarge, too);
   endtask

   // One-cycle Start, then watch a bounded window counting Busy and Done.
   task automatic run_conv(input logic [W-1:0] n, input logic enc,
                           output int busy_cycles, output int done_pulses);
      @(negedge Clock);
      bus.Start    = 1'b1;
      bus.N        = n;
      bus.Encoding = enc;
      @(negedge Clock);
      bus.Start   = 1'b0;
      busy_cycles = 0;
      done_pulses = 0;
      for (int i = 0; i < W + 9; i++) begin
         if (bus.Busy) busy_cycles++;
         if (bus.Done) done_pulses++;
         @(negedge Clock);
      end
   endtask

   task automatic count_done(input int cycles, output int dut_dones, output int model_dones);
      dut_dones   = 0;
      model_dones = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.Done) dut_dones++;
         if (m_done) model_dones++;
         @(negedge Clock);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, d, md;
      Reset        = 1'b1;
      bus.Start    = 1'b0;
      bus.N        = '0;
      bus.Encoding = 1'b0;
      repeat (3) @(negedge Clock);
      Reset  = 1'b0;
      cmp_en = 1'b1;

      chk_disp("reset", S_OFF, S_OFF, S_OFF, S_OFF, 1'b0);
      check("reset.busy", bus.Busy, 1'b0);
      check("reset.done", bus.Done, 1'b0);

      // 123, two's complement: latency and Busy width
      run_conv(11'd123, 1'b1, b, d);
      check("p123.busy_cycles", b, 13);
      check("p123.done_pulses", d, 1);
      chk_disp("p123", S_OFF, 7'b1111001, 7'b0100100, 7'b0110000, 1'b0);

      // -5 two's complement, leading digits blanked
      run_conv(11'h7FB, 1'b1, b, d);
      check("m5.done_pulses", d, 1);
      chk_disp("m5", S_MINUS, S_OFF, S_OFF, 7'b0010010, 1'b0);

      // Out of range then just in range
      run_conv(11'd1000, 1'b1, b, d);
      chk_disp("p1000", S_MINUS, S_MINUS, S_MINUS, S_MINUS, 1'b1);
      run_conv(11'd999, 1'b1, b, d);
      chk_disp("p999", S_OFF, 7'b0010000, 7'b0010000, 7'b0010000, 1'b0);

      // Sign-magnitude negative zero and -42
      run_conv(11'h400, 1'b0, b, d);
      chk_disp("smz", S_OFF, S_OFF, S_OFF, 7'b1000000, 1'b0);
      run_conv(11'h42A, 1'b0, b, d);
      chk_disp("sm42", S_MINUS, S_OFF, 7'b0011001, 7'b0100100, 1'b0);

      // Most negative two's complement value and plain zero
      run_conv(11'h400, 1'b1, b, d);
      chk_disp("m1024", S_MINUS, S_MINUS, S_MINUS, S_MINUS, 1'b1);
      run_conv(11'd0, 1'b1, b, d);
      chk_disp("zero", S_OFF, S_OFF, S_OFF, 7'b1000000, 1'b0);

      // Start while busy is ignored; inputs changing mid-conversion are ignored
      @(negedge Clock);
      bus.Start    = 1'b1;
      bus.N        = 11'd500;
      bus.Encoding = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      repeat (4) @(negedge Clock);
      bus.Start = 1'b1;
      bus.N     = 11'd7;
      @(negedge Clock);
      bus.Start    = 1'b0;
      bus.N        = 11'h7FF;
      bus.Encoding = 1'b0;
      count_done(2 * (W + 3), d, md);
      check("busy_start.dones", d, 1);
      chk_disp("p500", S_OFF, 7'b0010010, 7'b1000000, 7'b1000000, 1'b0);

      // Asynchronous reset in the middle of SHIFT aborts the conversion
      @(negedge Clock);
      bus.Start    = 1'b1;
      bus.N        = 11'd321;
      bus.Encoding = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      repeat (4) @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      chk_disp("async_rst", S_OFF, S_OFF, S_OFF, S_OFF, 1'b0);
      check("async_rst.busy", bus.Busy, 1'b0);
      check("async_rst.done", bus.Done, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      count_done(W + 8, d, md);
      check("abort.dones", d, 0);
      chk_disp("abort", S_OFF, S_OFF, S_OFF, S_OFF, 1'b0);
      run_conv(11'd88, 1'b1, b, d);
      check("after_rst.done_pulses", d, 1);
      chk_disp("p88", S_OFF, S_OFF, 7'b0000000, 7'b0000000, 1'b0);

      // Start held high re-triggers after each completed conversion
      @(negedge Clock);
      bus.Start    = 1'b1;
      bus.N        = 11'h419;
      bus.Encoding = 1'b1;
      count_done(40, d, md);
      bus.Start = 1'b0;
      check("held.dones_vs_model", d, md);
      check("held.retriggered", d >= 2, 1'b1);
      repeat (W + 6) @(negedge Clock);
      chk_disp("m999", S_MINUS, 7'b0010000, 7'b0010000, 7'b0010000, 1'b0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
